comm_master: RTL and testbench
==============================

COMM_MASTER -- requirements
Module: comm_master

Interface
REQ-001 SHALL provide parameter DUMP_LEN, default 384, the number of response bytes expected per dump command.
REQ-002 SHALL provide parameter TIMEOUT_CYC, default 1048576, the number of idle clk cycles allowed between bytes before a response is abandoned.
REQ-003 SHALL provide clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL provide rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide cmd  input  16  command word: [15:14] opcode (00 read, 01 write, 10 dump, 11 reserved), [13:8] address, [7:0] data.
REQ-006 SHALL provide snd_cmd  input  1  one-cycle request to issue cmd.
REQ-007 SHALL provide tx_data  output  8  byte to the UART transmitter.
REQ-008 SHALL provide trmt  output  1  one-cycle transmit strobe for tx_data.
REQ-009 SHALL provide tx_done  input  1  one-cycle pulse from the transmitter when the current byte is finished.
REQ-010 SHALL provide rx_data  input  8  byte from the UART receiver.
REQ-011 SHALL provide rx_rdy  input  1  level; rx_data is valid until it is cleared.
REQ-012 SHALL provide clr_rx_rdy  output  1  one-cycle acknowledge that consumes rx_data.
REQ-013 SHALL provide resp  output  8  last received response byte.
REQ-014 SHALL provide resp_rdy  output  1  one-cycle pulse when resp is updated.
REQ-015 SHALL provide busy  output  1  high in every state except IDLE.
REQ-016 SHALL provide cmd_cmplt  output  1  one-cycle pulse when a transaction ends.
REQ-017 SHALL provide timeout_err  output  1  sticky flag; set when a transaction ends by timeout.
REQ-018 SHALL provide byte_cnt  output  9  count of response bytes received in the current transaction.

Function
REQ-019 SHALL implement these states: IDLE, TX_HI, TX_LO, WAIT_RESP and DUMP.
REQ-020 SHALL sample snd_cmd only in IDLE; on acceptance it SHALL latch cmd, clear timeout_err and byte_cnt, and enter TX_HI.
REQ-021 SHALL ignore snd_cmd while busy is high.
REQ-022 SHALL assert trmt for exactly one cycle, in the cycle after the TX_HI entry, with tx_data equal to cmd[15:8].
REQ-023 SHALL hold tx_data stable until tx_done is received.
REQ-024 SHALL, on tx_done in TX_HI, enter TX_LO and in the next cycle pulse trmt with tx_data equal to cmd[7:0].
REQ-025 SHALL, on tx_done in TX_LO, enter DUMP if the opcode is 10, and WAIT_RESP otherwise, including the reserved opcode 11.
REQ-026 SHALL, in WAIT_RESP or DUMP, respond to rx_rdy in the same cycle by:
- pulsing clr_rx_rdy;
- registering resp equal to rx_data;
- pulsing resp_rdy in the next cycle;
- incrementing byte_cnt.
REQ-027 SHALL, in WAIT_RESP, return to IDLE and pulse cmd_cmplt after the first received byte.
REQ-028 SHALL, in DUMP, remain in DUMP until byte_cnt reaches DUMP_LEN, then return to IDLE and pulse cmd_cmplt.
REQ-029 SHALL, in DUMP, end the dump after one byte if the first byte is 8'hEE (negative acknowledge), with cmd_cmplt pulsed and byte_cnt equal to 1.
REQ-030 SHALL, in IDLE, TX_HI and TX_LO, discard any received byte by pulsing clr_rx_rdy without updating resp or resp_rdy.
REQ-031 SHALL run a timeout counter in WAIT_RESP and DUMP that clears on state entry and on every consumed byte.
REQ-032 SHALL, when the timeout counter reaches TIMEOUT_CYC-1, set timeout_err, pulse cmd_cmplt and return to IDLE.
REQ-033 SHALL give a consumed rx_rdy priority over the timeout when both occur in the same cycle.
REQ-034 SHALL never wrap byte_cnt past DUMP_LEN.
REQ-035 SHALL not wait on tx_done for a timeout; the transmitter is guaranteed to complete.

Reset
REQ-036 SHALL, while rst_n is low, force the state to IDLE and all outputs to 0, including resp, tx_data, byte_cnt and timeout_err.
REQ-037 SHALL, on reset asserted mid-transaction, abandon the transaction immediately with no cmd_cmplt pulse.
REQ-038 SHALL, after reset is released, accept a new snd_cmd on the first clock edge.

Verification
REQ-039 Write: snd_cmd with cmd 16'h4703 -> trmt bytes 8'h47 then 8'h03; responder returns 8'hA5 -> resp equals 8'hA5, resp_rdy pulses, cmd_cmplt pulses, byte_cnt equals 1.
REQ-040 Read: cmd 16'h0700 with reply 8'hAA -> resp equals 8'hAA, state WAIT_RESP then IDLE, timeout_err equals 0.
REQ-041 Dump: DUMP_LEN=4, cmd 16'h8002 with replies 8'h11, 8'h22, 8'h33, 8'h44 -> four resp_rdy pulses and one cmd_cmplt, byte_cnt equals 4.
REQ-042 Dump with negative acknowledge: cmd 16'h8007 with reply 8'hEE -> cmd_cmplt after one byte, byte_cnt equals 1.
REQ-043 Timeout: TIMEOUT_CYC=16, read with no reply -> cmd_cmplt and timeout_err 16 cycles after WAIT_RESP entry; a later snd_cmd clears timeout_err.
REQ-044 Reset and discard: rst_n pulsed low during TX_LO -> all outputs 0 and no cmd_cmplt; an extra snd_cmd while busy is ignored; rx_rdy in IDLE is cleared with no resp_rdy.

Source files
------------

// File: rtl/comm_master.sv
// UART command master: sends a 2-byte command, then collects one reply byte or a DUMP_LEN-byte dump.
// Replies are abandoned after TIMEOUT_CYC idle cycles; received bytes are acknowledged in the same cycle they are seen.
module comm_master #(
    parameter int DUMP_LEN    = 384,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rx_rdy,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    output logic        busy,
    output logic        cmd_cmplt,
    output logic        timeout_err,
    output logic [8:0]  byte_cnt
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [8:0]    CNT_LAST = 9'(DUMP_LEN);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] TX_HI     = 3'd1;
    localparam logic [2:0] TX_LO     = 3'd2;
    localparam logic [2:0] WAIT_RESP = 3'd3;
    localparam logic [2:0] DUMP      = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [15:0]   cmd_q, cmd_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          trmt_q, trmt_d;
    logic [7:0]    resp_q, resp_d;
    logic          resp_rdy_q, resp_rdy_d;
    logic          cmd_cmplt_q, cmd_cmplt_d;
    logic          timeout_err_q, timeout_err_d;
    logic [8:0]    byte_cnt_q, byte_cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        tx_data_d     = tx_data_q;
        trmt_d        = 1'b0;
        resp_d        = resp_q;
        resp_rdy_d    = 1'b0;
        cmd_cmplt_d   = 1'b0;
        timeout_err_d = timeout_err_q;
        byte_cnt_d    = byte_cnt_q;
        tmr_d         = '0;
        case (state_q)
            IDLE: begin
                if (snd_cmd) begin
                    cmd_d         = cmd;
                    tx_data_d     = cmd[15:8];
                    trmt_d        = 1'b1;
                    timeout_err_d = 1'b0;
                    byte_cnt_d    = '0;
                    state_d       = TX_HI;
                end
            end
            TX_HI: begin
                if (tx_done) begin
                    tx_data_d = cmd_q[7:0];
                    trmt_d    = 1'b1;
                    state_d   = TX_LO;
                end
            end
            TX_LO: begin
                if (tx_done) begin
                    state_d = (cmd_q[15:14] == 2'b10) ? DUMP : WAIT_RESP;
                end
            end
            WAIT_RESP, DUMP: begin
                // A byte arriving in the expiry cycle still counts and wins over the timeout.
                if (rx_rdy) begin
                    resp_d     = rx_data;
                    resp_rdy_d = 1'b1;
                    if (byte_cnt_q != CNT_LAST) begin
                        byte_cnt_d = byte_cnt_q + 9'd1;
                    end
                    if ((state_q == WAIT_RESP) ||
                        ((byte_cnt_q == 9'd0) && (rx_data == 8'hEE)) ||
                        ((byte_cnt_q + 9'd1) >= CNT_LAST)) begin
                        cmd_cmplt_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else if (tmr_q == TMR_LAST) begin
                    timeout_err_d = 1'b1;
                    cmd_cmplt_d   = 1'b1;
                    state_d       = IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            tx_data_q     <= '0;
            trmt_q        <= 1'b0;
            resp_q        <= '0;
            resp_rdy_q    <= 1'b0;
            cmd_cmplt_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            byte_cnt_q    <= '0;
            tmr_q         <= '0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            tx_data_q     <= tx_data_d;
            trmt_q        <= trmt_d;
            resp_q        <= resp_d;
            resp_rdy_q    <= resp_rdy_d;
            cmd_cmplt_q   <= cmd_cmplt_d;
            timeout_err_q <= timeout_err_d;
            byte_cnt_q    <= byte_cnt_d;
            tmr_q         <= tmr_d;
        end
    end

    // Every state drains the receiver; only the response states keep the byte.
    assign clr_rx_rdy  = rx_rdy & rst_n;
    assign tx_data     = tx_data_q;
    assign trmt        = trmt_q;
    assign resp        = resp_q;
    assign resp_rdy    = resp_rdy_q;
    assign busy        = (state_q != IDLE);
    assign cmd_cmplt   = cmd_cmplt_q;
    assign timeout_err = timeout_err_q;
    assign byte_cnt    = byte_cnt_q;

endmodule

// File: tb/tb_comm_master.sv
// Bench for comm_master: directed scenarios plus randomized transactions checked against a list-based reply model.
module tb_comm_master;

    localparam int DL = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cmd = '0;
    logic        snd_cmd = 1'b0;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_rdy = 1'b0;
    logic        clr_rx_rdy;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        busy;
    logic        cmd_cmplt;
    logic        timeout_err;
    logic [8:0]  byte_cnt;

    comm_master #(.DUMP_LEN(DL), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .snd_cmd(snd_cmd),
        .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
        .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy),
        .resp(resp), .resp_rdy(resp_rdy), .busy(busy), .cmd_cmplt(cmd_cmplt),
        .timeout_err(timeout_err), .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_pass = 0;
    int         trmt_cnt = 0;
    int         cmplt_cnt = 0;
    logic [7:0] resp_log[$];
    logic [7:0] exp_q[$];
    bit         exp_to;
    logic [7:0] rep[8];
    logic [7:0] last_resp = 8'h00;

    always @(negedge clk) begin
        if (trmt) trmt_cnt++;
        if (resp_rdy) resp_log.push_back(resp);
        if (cmd_cmplt) cmplt_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected responses from the command rules: one byte for non-dump opcodes,
    // DUMP_LEN bytes for a dump unless the first is a NAK; missing bytes mean timeout.
    task automatic model(input logic [15:0] c, input int n);
        exp_q = {};
        if (c[15:14] != 2'b10) begin
            if (n > 0) exp_q.push_back(rep[0]);
            exp_to = (n == 0);
        end else if (n > 0 && rep[0] == 8'hEE) begin
            exp_q.push_back(8'hEE);
            exp_to = 1'b0;
        end else begin
            for (int k = 0; k < n && k < DL; k++) exp_q.push_back(rep[k]);
            exp_to = (n < DL);
        end
    endtask

    task automatic run_txn(input logic [15:0] c, input int n, input bit poke);
        int t0, c0, r0, d, w;
        t0 = trmt_cnt;
        c0 = cmplt_cnt;
        r0 = resp_log.size();
        model(c, n);
        cmd = c;
        snd_cmd = 1'b1;
        tick();
        snd_cmd = 1'b0;
        cmd = 16'($urandom);
        chk("accept_busy", 32'(busy), 32'd1);
        chk("tx_hi_trmt", 32'(trmt), 32'd1);
        chk("tx_hi_data", 32'(tx_data), 32'(c[15:8]));
        chk("err_clear", 32'(timeout_err), 32'd0);
        chk("cnt_clear", 32'(byte_cnt), 32'd0);
        d = $urandom_range(1, 4);
        for (int i = 0; i < d; i++) begin
            if (poke && i == 0) begin
                snd_cmd = 1'b1;
                cmd = 16'hFFFF;
            end
            tick();
            snd_cmd = 1'b0;
        end
        chk("tx_hi_hold", 32'(tx_data), 32'(c[15:8]));
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("tx_lo_trmt", 32'(trmt), 32'd1);
        chk("tx_lo_data", 32'(tx_data), 32'(c[7:0]));
        repeat ($urandom_range(1, 4)) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        if (n == 0 && c[15:14] != 2'b10) begin
            repeat (TO - 1) tick();
            chk("to_early", 32'(cmd_cmplt), 32'd0);
            chk("to_wait_busy", 32'(busy), 32'd1);
            tick();
            chk("to_cmplt", 32'(cmd_cmplt), 32'd1);
            chk("to_err", 32'(timeout_err), 32'd1);
        end else begin
            for (int j = 0; j < n; j++) begin
                repeat ($urandom_range(0, 3)) tick();
                rx_data = rep[j];
                rx_rdy = 1'b1;
                tick();
                rx_rdy = 1'b0;
            end
        end
        w = 0;
        while (busy && w < 40) begin
            tick();
            w++;
        end
        chk("done_in_time", 32'(busy), 32'd0);
        tick();
        tick();
        chk("trmt_pulses", 32'(trmt_cnt - t0), 32'd2);
        chk("cmplt_pulses", 32'(cmplt_cnt - c0), 32'd1);
        chk("resp_count", 32'(resp_log.size() - r0), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && (r0 + k) < resp_log.size(); k++)
            chk("resp_byte", 32'(resp_log[r0 + k]), 32'(exp_q[k]));
        chk("byte_cnt", 32'(byte_cnt), 32'(exp_q.size()));
        chk("timeout_err", 32'(timeout_err), 32'(exp_to));
        if (exp_q.size() > 0) last_resp = exp_q[exp_q.size() - 1];
        chk("resp_final", 32'(resp), 32'(last_resp));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_trmt"}, 32'(trmt), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_resp"}, 32'(resp), 32'd0);
        chk({tag, "_resp_rdy"}, 32'(resp_rdy), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_cmplt"}, 32'(cmd_cmplt), 32'd0);
        chk({tag, "_to_err"}, 32'(timeout_err), 32'd0);
        chk({tag, "_byte_cnt"}, 32'(byte_cnt), 32'd0);
        chk({tag, "_clr_rx"}, 32'(clr_rx_rdy), 32'd0);
    endtask

    initial begin
        int c0, r0, n, kind;
        logic [15:0] c;

        rx_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rx_rdy = 1'b0;
        rst_n = 1'b1;

        rep[0] = 8'hA5;
        run_txn(16'h4703, 1, 1'b1);
        rep[0] = 8'hAA;
        run_txn(16'h0700, 1, 1'b0);
        rep[0] = 8'h11; rep[1] = 8'h22; rep[2] = 8'h33; rep[3] = 8'h44;
        run_txn(16'h8002, 4, 1'b0);
        rep[0] = 8'hEE;
        run_txn(16'h8007, 1, 1'b0);
        run_txn(16'h0700, 0, 1'b0);
        rep[0] = 8'hA5;
        run_txn(16'h4703, 1, 1'b0);

        c0 = cmplt_cnt;
        cmd = 16'h4100;
        snd_cmd = 1'b1;
        tick();
        snd_cmd = 1'b0;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        repeat (3) tick();
        chk("mid_reset_no_cmplt", 32'(cmplt_cnt - c0), 32'd0);
        rst_n = 1'b1;
        last_resp = 8'h00;
        rep[0] = 8'h3C;
        run_txn(16'h0123, 1, 1'b0);

        r0 = resp_log.size();
        rx_data = 8'h5A;
        rx_rdy = 1'b1;
        #1;
        chk("idle_clr_rx", 32'(clr_rx_rdy), 32'd1);
        tick();
        rx_rdy = 1'b0;
        tick();
        tick();
        chk("idle_no_resp_rdy", 32'(resp_log.size() - r0), 32'd0);
        chk("idle_resp_kept", 32'(resp), 32'(last_resp));

        for (int t = 0; t < 30; t++) begin
            c = 16'($urandom);
            for (int k = 0; k < 8; k++) rep[k] = 8'($urandom);
            if (c[15:14] == 2'b10) begin
                kind = $urandom_range(0, 3);
                if (kind == 0) begin
                    rep[0] = 8'hEE;
                    n = 1;
                end else begin
                    if (rep[0] == 8'hEE) rep[0] = 8'h01;
                    n = (kind == 1) ? $urandom_range(0, DL - 1) : DL;
                end
            end else begin
                n = ($urandom_range(0, 4) == 0) ? 0 : 1;
            end
            run_txn(c, n, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
